// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive controller.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_e;

    localparam logic [7:0] PRESCALE_8  = 8'd8;
    localparam logic [7:0] PRESCALE_16 = 8'd16;
    localparam logic [7:0] PRESCALE_32 = 8'd32;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    function automatic logic parity_bit(input logic xor_all, input logic typ);
        return (typ == PAR_ODD) ? ~xor_all : xor_all;
    endfunction

endpackage

// File: rtl/uart_rx_edge_bit_counter.sv
// Clock-within-bit and bit-within-frame counters for the UART receiver.
module uart_rx_edge_bit_counter #(
    parameter int DATA_WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cnt_en,
    input  logic       bit_clr,
    input  logic [7:0] prescale,
    output logic [7:0] edge_count,
    output logic       bit_end,
    output logic       last_bit
);

    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    logic [7:0]    edge_q, edge_d;
    logic [BW-1:0] bit_q, bit_d;

    assign edge_count = edge_q;
    assign bit_end    = (edge_q == 8'(prescale - 8'd1));
    assign last_bit   = (bit_q == BW'(DATA_WIDTH - 1));

    always_comb begin
        edge_d = edge_q;
        bit_d  = bit_q;
        if (!cnt_en || bit_end) begin
            edge_d = 8'd0;
        end else begin
            edge_d = edge_q + 8'd1;
        end
        // bit index only advances inside the payload
        if (bit_clr) begin
            bit_d = '0;
        end else if (cnt_en && bit_end && !last_bit) begin
            bit_d = bit_q + BW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            edge_q <= 8'd0;
            bit_q  <= '0;
        end else begin
            edge_q <= edge_d;
            bit_q  <= bit_d;
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: frame FSM driving an external majority sampler.
import uart_rx_pkg::*;

module uart_rx_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in,
    input  logic [7:0]            prescale,
    input  logic                  par_en,
    input  logic                  par_typ,
    input  logic                  sampled_data,
    input  logic                  sample_valid,
    output logic                  dat_samp_en,
    output logic [15:0]           edge_count,
    output logic [DATA_WIDTH-1:0] p_data,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err
);

    rx_state_e             state_q, state_d;
    logic [7:0]            presc_q, presc_d;
    logic                  pen_q, pen_d;
    logic                  ptyp_q, ptyp_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
    logic                  perr_q, perr_d;
    logic                  dv_q, dv_d;
    logic                  pe_q, pe_d;
    logic                  se_q, se_d;

    logic [7:0] edge_cnt;
    logic       bit_end;
    logic       last_bit;
    logic       cnt_en;

    assign cnt_en      = (state_q != ST_IDLE) && (state_d != ST_IDLE);
    assign dat_samp_en = (state_q != ST_IDLE);
    assign edge_count  = 16'(edge_cnt);
    assign p_data      = p_data_q;
    assign data_valid  = dv_q;
    assign par_err     = pe_q;
    assign stp_err     = se_q;

    uart_rx_edge_bit_counter #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_cnt (
        .clk       (clk),
        .rst       (rst),
        .cnt_en    (cnt_en),
        .bit_clr   (state_q != ST_DATA),
        .prescale  (presc_q),
        .edge_count(edge_cnt),
        .bit_end   (bit_end),
        .last_bit  (last_bit)
    );

    always_comb begin
        state_d  = state_q;
        presc_d  = presc_q;
        pen_d    = pen_q;
        ptyp_d   = ptyp_q;
        shift_d  = shift_q;
        p_data_d = p_data_q;
        perr_d   = perr_q;
        dv_d     = 1'b0;
        pe_d     = 1'b0;
        se_d     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                perr_d = 1'b0;
                if (!rx_in) begin
                    state_d = ST_START;
                    presc_d = prescale;
                    pen_d   = par_en;
                    ptyp_d  = par_typ;
                end
            end
            ST_START: begin
                if (sample_valid && sampled_data) begin
                    state_d = ST_IDLE;
                end else if (bit_end) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (sample_valid) begin
                    shift_d = {sampled_data, shift_q[DATA_WIDTH-1:1]};
                end
                if (bit_end && last_bit) begin
                    state_d = pen_q ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (sample_valid &&
                    (sampled_data != parity_bit(^shift_q, ptyp_q))) begin
                    perr_d = 1'b1;
                end
                if (bit_end) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                // leave mid-bit so a following start edge is not missed
                if (sample_valid) begin
                    state_d = ST_IDLE;
                    if (sampled_data && !perr_q) begin
                        dv_d     = 1'b1;
                        p_data_d = shift_q;
                    end else begin
                        pe_d = perr_q;
                        se_d = !sampled_data;
                    end
                end else if (bit_end) begin
                    state_d = ST_IDLE;
                    pe_d    = perr_q;
                    se_d    = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            presc_q  <= PRESCALE_8;
            pen_q    <= 1'b0;
            ptyp_q   <= PAR_EVEN;
            shift_q  <= '0;
            p_data_q <= '0;
            perr_q   <= 1'b0;
            dv_q     <= 1'b0;
            pe_q     <= 1'b0;
            se_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            pen_q    <= pen_d;
            ptyp_q   <= ptyp_d;
            shift_q  <= shift_d;
            p_data_q <= p_data_d;
            perr_q   <= perr_d;
            dv_q     <= dv_d;
            pe_q     <= pe_d;
            se_q     <= se_d;
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl with a behavioural line driver and sampler.
module tb_uart_rx_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_in = 1'b1;
    logic [7:0]  prescale = 8'd8;
    logic        par_en = 1'b0;
    logic        par_typ = 1'b0;
    logic        sampled_data;
    logic        sample_valid;
    logic        dat_samp_en;
    logic [15:0] edge_count;
    logic [7:0]  p_data;
    logic        data_valid;
    logic        par_err;
    logic        stp_err;

    uart_rx_ctrl #(
        .DATA_WIDTH(8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_in       (rx_in),
        .prescale    (prescale),
        .par_en      (par_en),
        .par_typ     (par_typ),
        .sampled_data(sampled_data),
        .sample_valid(sample_valid),
        .dat_samp_en (dat_samp_en),
        .edge_count  (edge_count),
        .p_data      (p_data),
        .data_valid  (data_valid),
        .par_err     (par_err),
        .stp_err     (stp_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Sampler: majority of three mid-bit samples, strobed one cycle later.
    int         sp = 8;
    logic [2:0] hist = 3'b111;
    always @(posedge clk) hist <= {hist[1:0], rx_in};
    assign sampled_data = (hist[0] & hist[1]) | (hist[0] & hist[2]) |
                          (hist[1] & hist[2]);
    assign sample_valid = dat_samp_en && (edge_count == 16'(sp / 2 + 2));

    typedef struct {
        int         cyc;
        logic       dv;
        logic       pe;
        logic       se;
        logic [7:0] data;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Monitor
    logic [7:0] last_good = 8'h00;
    exp_t       m;
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                last_good = 8'h00;
            end else if (data_valid || par_err || stp_err) begin
                if (q.size() == 0) begin
                    check("unexpected_pulse",
                          32'({data_valid, par_err, stp_err}), 32'd0);
                end else begin
                    m = q.pop_front();
                    check("pulse_cycle", 32'(cyc), 32'(m.cyc));
                    check("data_valid", 32'(data_valid), 32'(m.dv));
                    check("par_err", 32'(par_err), 32'(m.pe));
                    check("stp_err", 32'(stp_err), 32'(m.se));
                    if (m.dv) begin
                        check("p_data", 32'(p_data), 32'(m.data));
                        last_good = m.data;
                    end else begin
                        check("p_data_held", 32'(p_data), 32'(last_good));
                    end
                end
            end
        end
    end

    task automatic hold(input logic v, input int k);
        rx_in = v;
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input int p,
                              input logic pen, input logic ptyp,
                              input logic bad_par, input logic stop_bit,
                              input int gap, input logic scramble);
        exp_t e;
        logic pbit;
        pbit     = (^d) ^ ptyp ^ bad_par;
        sp       = p;
        prescale = 8'(p);
        par_en   = pen;
        par_typ  = ptyp;
        e.cyc    = cyc + 9 * p + p / 2 + 4 + (pen ? p : 0);
        e.pe     = pen && bad_par;
        e.se     = !stop_bit;
        e.dv     = stop_bit && !e.pe;
        e.data   = d;
        q.push_back(e);
        hold(1'b0, p);
        if (scramble) begin
            prescale = 8'($urandom);
            par_en   = 1'($urandom);
            par_typ  = 1'($urandom);
        end
        for (int i = 0; i < 8; i++) hold(d[i], p);
        if (pen) hold(pbit, p);
        prescale = 8'(p);
        par_en   = pen;
        par_typ  = ptyp;
        hold(stop_bit, p);
        hold(1'b1, gap);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_dat_samp_en"}, 32'(dat_samp_en), 32'd0);
        check({tag, "_edge_count"}, 32'(edge_count), 32'd0);
        check({tag, "_p_data"}, 32'(p_data), 32'd0);
        check({tag, "_pulses"}, 32'({data_valid, par_err, stp_err}), 32'd0);
    endtask

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        int p;
        logic pen;
        logic stopb;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_quiet("reset");
        rst = 1'b0;

        // 0xA5 at prescale 8 starting in cycle 100
        while (cyc < 100) begin
            @(posedge clk);
            #1;
        end
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1, 20, 1'b0);

        // Even parity: good then corrupted parity bit
        send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b0, 1'b1, 4, 1'b0);
        send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1, 1'b1, 4, 1'b0);

        // Two-cycle glitch
        sp = 8;
        prescale = 8'd8;
        g = cyc;
        hold(1'b0, 2);
        hold(1'b1, 2);
        check("glitch_samp_en_on", 32'(dat_samp_en), 32'd1);
        hold(1'b1, g + 9 - cyc);
        check("glitch_samp_en_off", 32'(dat_samp_en), 32'd0);
        hold(1'b1, 10);

        // Bad stop bit, then a clean frame
        send_frame(8'h81, 8, 1'b0, 1'b0, 1'b0, 1'b0, 16, 1'b0);
        send_frame(8'h42, 8, 1'b0, 1'b0, 1'b0, 1'b1, 2, 1'b0);

        // Back-to-back at prescale 32
        send_frame(8'h11, 32, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        send_frame(8'h22, 32, 1'b0, 1'b0, 1'b0, 1'b1, 4, 1'b0);

        // Reset in the middle of data bit 4
        sp = 8;
        prescale = 8'd8;
        par_en = 1'b0;
        hold(1'b0, 8);
        for (int i = 0; i < 4; i++) hold(g[i], 8);
        hold(1'b0, 3);
        rst = 1'b1;
        rx_in = 1'b1;
        @(posedge clk);
        #1;
        check_quiet("midreset");
        rst = 1'b0;
        hold(1'b1, 5);
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1'b1, 3, 1'b0);

        // Randomised frames
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(2, 0))
                0: p = 8;
                1: p = 16;
                default: p = 32;
            endcase
            pen   = 1'($urandom);
            stopb = ($urandom_range(4, 0) != 0);
            send_frame(8'($urandom), p, pen, 1'($urandom),
                       pen && ($urandom_range(4, 0) == 0), stopb,
                       stopb ? $urandom_range(3, 0) : p + 8,
                       1'($urandom));
        end

        for (int i = 0; i < 400 && q.size() != 0; i++) begin
            @(posedge clk);
        end
        check("queue_drained", 32'(q.size()), 32'd0);
        repeat (10) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning payload bits per frame.
REQ-002 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port rx_in  input  1  serial line, idle high, already synchronous to clk; no internal synchronizer.
REQ-005 SHALL have port prescale  input  8  clocks per bit; legal values 8, 16, 32.
REQ-006 SHALL have port par_en  input  1  parity bit present when 1.
REQ-007 SHALL have port par_typ  input  1  0 even, 1 odd.
REQ-008 SHALL have port sampled_data  input  1  majority-voted bit from the sampler.
REQ-009 SHALL have port sample_valid  input  1  one-cycle strobe; sampled_data is valid when high.
REQ-010 SHALL have port dat_samp_en  output  1  sampler enable.
REQ-011 SHALL have port edge_count  output  16  clock index within the current bit, zero-extended.
REQ-012 SHALL have port p_data  output  DATA_WIDTH  received payload.
REQ-013 SHALL have port data_valid  output  1  one-cycle pulse; p_data is good.
REQ-014 SHALL have port par_err  output  1  one-cycle pulse; parity mismatch.
REQ-015 SHALL have port stp_err  output  1  one-cycle pulse; stop bit sampled low.

Function
REQ-016 SHALL implement the states IDLE, START, DATA, PARITY and STOP.
REQ-017 IDLE: edge_count=0 and dat_samp_en=0; rx_in==0 in cycle n SHALL move to START at n+1 with edge_count=0, and SHALL latch prescale, par_en and par_typ.
REQ-018 SHALL assert dat_samp_en whenever state!=IDLE.
REQ-019 In non-IDLE states, edge_count SHALL increment by 1 per cycle and wrap to 0 after latched prescale-1; bit boundary = the cycle edge_count==prescale-1.
REQ-020 START: sample_valid with sampled_data==1 SHALL be treated as a glitch: return to IDLE next cycle, no output pulses; otherwise at the bit boundary go to DATA with bit_count=0.
REQ-021 DATA: each sample_valid SHALL shift sampled_data into the payload register LSB-first; at the bit boundary bit_count SHALL increment, or on bit_count==DATA_WIDTH-1 go to PARITY if latched par_en, else STOP.
REQ-022 PARITY: on sample_valid, expected bit SHALL be the XOR of the payload for even parity and its inverse for odd; a mismatch SHALL set an internal error flag; at the bit boundary go to STOP.
REQ-023 STOP: on sample_valid, the state SHALL return to IDLE on the next cycle (early return, half-bit margin for back-to-back frames); outputs SHALL be registered and appear one cycle after the sample_valid cycle.
REQ-024 At frame end, SHALL pulse data_valid and update p_data only if the stop bit is 1 and there is no parity error; otherwise SHALL pulse par_err and/or stp_err, leaving p_data unchanged.
REQ-025 p_data SHALL hold its last good value between frames.
REQ-026 Changes to prescale, par_en or par_typ mid-frame SHALL have no effect until the next start detection.
REQ-027 sample_valid while in IDLE SHALL be ignored.
REQ-028 Latency: with start edge in cycle n, no parity and P=prescale, data_valid SHALL assert in cycle n+9P+P/2+4.

Reset
REQ-029 rst high SHALL, at the next edge, force IDLE, edge_count=0, bit_count=0, p_data=0, and data_valid=par_err=stp_err=dat_samp_en=0, including mid-frame.
REQ-030 A frame interrupted by reset SHALL produce no pulses; reception SHALL resume at the first rx_in low after rst deasserts.

Structure
REQ-031 A shared package uart_rx_pkg SHALL hold the state encoding, legal prescale constants (8/16/32) and the parity-type encodings.
REQ-032 The edge and bit counters SHALL live in one sub-module, uart_rx_edge_bit_counter, with the FSM in uart_rx_ctrl.

Verification
REQ-033 prescale=8, no parity, frame 0xA5, start edge at cycle 100: data_valid pulses once at cycle 180 with p_data=0xA5.
REQ-034 prescale=16, par_en=1, par_typ=0, byte 0x3C sent with parity 0: data_valid with p_data=0x3C; the same frame sent with parity 1 gives par_err pulse, no data_valid, p_data unchanged.
REQ-035 prescale=8, rx_in low for 2 cycles then high: START then IDLE, dat_samp_en drops, no output pulses.
REQ-036 prescale=8, byte 0x81 with stop bit 0: stp_err pulse, no data_valid; a following frame 0x42 is received correctly.
REQ-037 Back-to-back frames 0x11, 0x22 at prescale=32 with a single stop bit: two data_valid pulses carrying 0x11 and 0x22 in order.
REQ-038 rst asserted in DATA at bit 4: next cycle IDLE with all outputs 0; the next full frame 0x5A is received correctly.
